soc_system_key_debounce: RTL
============================

Name: soc_system_key_debounce

Overview:
- Upstream input-conditioning stage for the 4-bit key/switch PIO on the Avalon bus.
- Takes raw, asynchronous, bouncing push-button levels from the board.
- Synchronises and debounces them, then drives the clean levels into the PIO's in_port.
- Also emits one-cycle press/release strobes for edge-capture or IRQ logic.

Parameters:
- WIDTH, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles (20 ms at 50 MHz) required to accept a new level. Legal range 2..2^CNT_W-1.
- CNT_W, 20, width of the per-channel stability counter.
- RESET_VALUE, all ones, reset level of the synchroniser and of key_db (keys are active-low, idle high).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- key_raw  input  WIDTH  raw board key levels, asynchronous to clk; 0 = pressed.
- key_db  output  WIDTH  debounced level, feeds PIO in_port.
- key_press  output  WIDTH  one-cycle strobe when key_db[i] goes 1->0.
- key_release  output  WIDTH  one-cycle strobe when key_db[i] goes 0->1.

Behaviour:
- Reset and clocking: reset_n is asynchronous, active-low; clock is clk.
- Reset values:
  - sync stages, key_db: RESET_VALUE
  - key_press, key_release: 0
  - counters: 0
  - all channels in STABLE
- Synchroniser: a 2-FF synchroniser per bit; sync = second stage. No other logic samples key_raw.
- Per-channel FSM, two states:
  - STABLE:
    - sync == key_db: stay, cnt = 0.
    - sync != key_db: go to COUNTING, cnt <= 1.
  - COUNTING:
    - sync == key_db (bounce back): go to STABLE, cnt <= 0. No output change.
    - sync != key_db and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
    - sync != key_db and cnt == DEBOUNCE_CYCLES-1: key_db <= sync, strobe, go to STABLE, cnt <= 0.
- Latency: key_raw changes and holds from before edge k.
  - key_db updates on edge k+1+DEBOUNCE_CYCLES.
  - This is exactly DEBOUNCE_CYCLES consecutive mismatching samples.
- Strobes:
  - Registered, and updated on the same edge as key_db.
  - key_press[i] = 1 for exactly one cycle on a 1->0 transition; key_release[i] likewise on 0->1.
  - Never both set for the same channel in one cycle.
- Bounce: any mismatch run shorter than DEBOUNCE_CYCLES produces no key_db change and no strobe. The counter fully restarts on each bounce.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own strobes in the same cycle.
- Counter never wraps: maximum value DEBOUNCE_CYCLES-1. The CNT_W check is a synthesis-time assertion on the parameter range.
- Reset mid-count: all state returns to reset values immediately.
  - No strobe is produced on or after reset release for the aborted transition.
  - A key held pressed through reset is re-qualified from zero after reset release and yields a key_press strobe.
- No combinational path from key_raw to any output.

Decomposition:
- Shared package soc_system_key_pkg:
  - FSM state typedef (ST_STABLE, ST_COUNTING)
  - default DEBOUNCE_CYCLES constant
  - default KEY_IDLE level constant
- Sub-module key_debounce_channel:
  - one bit: synchroniser, counter, FSM, key_db bit, press and release strobes
  - instantiated WIDTH times in a generate loop by soc_system_key_debounce
  - parameters DEBOUNCE_CYCLES, CNT_W, RESET_VALUE bit

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset: reset_n low with key_raw=4'h0 -> key_db=4'hF, key_press=key_release=0 throughout reset; after release, key_press=4'hF pulses one cycle 6 edges later.
- Clean press: key_raw[0] 1->0 before edge 10, held -> key_db=4'hE after edge 15; key_press=4'h1 for exactly the cycle following edge 15; no other strobes.
- Bounce rejection: key_raw[1] toggles every 3 cycles for 30 cycles, then returns high -> key_db stays 4'hF, no strobes.
- Release: from key_db=4'hE, key_raw[0] 0->1 held -> key_db=4'hF 5 edges later; key_release=4'h1 one cycle; key_press=0.
- Simultaneous: key_raw 4'hF->4'h5 at one edge -> key_db=4'h5 and key_press=4'hA in the same cycle.
- Reset mid-count: key_raw[2] driven low; reset_n pulsed low after 2 counting cycles while key_raw[2] returns high -> key_db=4'hF, no strobe at any time.

Source files
------------

// File: rtl/soc_system_key_pkg.sv
// soc_system_key_pkg: shared types and defaults for the key debounce block
package soc_system_key_pkg;
    typedef enum logic {ST_STABLE, ST_COUNTING} key_state_e;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam logic KEY_IDLE = 1'b1;
endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one-bit synchroniser, stability counter and press/release strobes
module key_debounce_channel
    import soc_system_key_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int   CNT_W           = 20,
    parameter logic RESET_VALUE     = KEY_IDLE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_db,
    output logic key_press,
    output logic key_release
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 2**CNT_W - 1) begin : g_bad_range
        $error("DEBOUNCE_CYCLES out of range for CNT_W");
    end
    key_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sync1, sync, mismatch, done, db_n, press_n, release_n;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= RESET_VALUE;
            sync        <= RESET_VALUE;
            state       <= ST_STABLE;
            cnt         <= '0;
            key_db      <= RESET_VALUE;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= key_raw;
            sync        <= sync1;
            state       <= state_n;
            cnt         <= cnt_n;
            key_db      <= db_n;
            key_press   <= press_n;
            key_release <= release_n;
        end
    end
    assign mismatch = sync != key_db;
    assign done     = state == ST_COUNTING && mismatch && cnt == CNT_MAX;
    // cnt is 0 in STABLE, so cnt+1 also covers the STABLE->COUNTING entry value of 1
    always_comb begin
        state_n = (mismatch && !done) ? ST_COUNTING : ST_STABLE;
        cnt_n   = (mismatch && !done) ? cnt + 1'b1 : '0;
    end
    always_comb begin
        db_n      = done ? sync : key_db;
        press_n   = done && !sync;
        release_n = done && sync;
    end
endmodule

// File: rtl/soc_system_key_debounce.sv
// soc_system_key_debounce: synchronise and debounce board keys for the PIO in_port
module soc_system_key_debounce
    import soc_system_key_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int               CNT_W           = 20,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{KEY_IDLE}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_db,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .RESET_VALUE    (RESET_VALUE[i])
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .key_raw    (key_raw[i]),
            .key_db     (key_db[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end
endmodule
